// File: rtl/sd_cmd_sequencer_if.sv
// Command/response and SPI byte-engine signals of the SD command sequencer.
// master = controller plus byte engine side, slave = the sequencer itself.
`timescale 1ns/1ps
interface sd_cmd_sequencer_if;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_long;
    logic        cmd_ready;
    logic        resp_valid;
    logic [7:0]  resp_r1;
    logic [31:0] resp_data;
    logic        resp_timeout;
    logic        spi_start;
    logic [7:0]  spi_tx;
    logic        spi_done;
    logic [7:0]  spi_rx;
    logic        spi_cs_n;

    modport master (
        output cmd_valid, cmd_index, cmd_arg, cmd_long,
        input  cmd_ready, resp_valid, resp_r1, resp_data, resp_timeout,
        input  spi_start, spi_tx, spi_cs_n,
        output spi_done, spi_rx
    );

    modport slave (
        input  cmd_valid, cmd_index, cmd_arg, cmd_long,
        output cmd_ready, resp_valid, resp_r1, resp_data, resp_timeout,
        output spi_start, spi_tx, spi_cs_n,
        input  spi_done, spi_rx
    );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// SD SPI-mode command sequencer: frame, R1 poll, optional R3/R7 tail, trailing clocks.
// Define SD_CRC7_EN to compute a real CRC7; otherwise fixed CRC bytes are sent.
`timescale 1ns/1ps
module sd_cmd_sequencer #(
    parameter int POLL_MAX    = 8,
    parameter int TRAIL_BYTES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    sd_cmd_sequencer_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, SEND, POLL, EXT, TRAIL, DONE} state_t;

    localparam logic [7:0] POLL_LAST  = 8'(POLL_MAX);
    localparam logic [1:0] TRAIL_LAST = (TRAIL_BYTES > 0) ? 2'(TRAIL_BYTES - 1) : 2'd0;

    state_t      state_reg, state_next;
    logic [5:0]  idx_reg, idx_next;
    logic [31:0] arg_reg, arg_next;
    logic        long_reg, long_next;
    logic [7:0]  crc_byte_reg, crc_byte_next;
    logic [2:0]  byte_cnt_reg, byte_cnt_next;
    logic [7:0]  poll_cnt_reg, poll_cnt_next;
    logic [1:0]  ext_cnt_reg, ext_cnt_next;
    logic [1:0]  trail_cnt_reg, trail_cnt_next;
    logic        pending_reg, pending_next;
    logic        spi_start_reg, spi_start_next;
    logic [7:0]  spi_tx_reg, spi_tx_next;
    logic        spi_cs_n_reg, spi_cs_n_next;
    logic        resp_valid_reg, resp_valid_next;
    logic [7:0]  resp_r1_reg, resp_r1_next;
    logic [31:0] resp_data_reg, resp_data_next;
    logic        resp_timeout_reg, resp_timeout_next;

    logic [7:0]  crc_byte_in;
    logic [7:0]  frame_byte [6];
    logic [2:0]  byte_idx;
    logic        done_ok;
    logic        issue;
    logic [7:0]  issue_byte;
    logic        go_trail;

`ifdef SD_CRC7_EN
    // CRC7, x^7 + x^3 + 1, zero init, message shifted in MSB first.
    function automatic logic [6:0] crc7_calc(input logic [39:0] msg);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = crc[6] ^ msg[i];
            crc = {crc[5:0], 1'b0};
            if (fb) crc = crc ^ 7'h09;
        end
        return crc;
    endfunction

    assign crc_byte_in = {crc7_calc({2'b01, bus.cmd_index, bus.cmd_arg}), 1'b1};
`else
    // CRC is only checked by the card for CMD0 and CMD8 in SPI mode.
    assign crc_byte_in = (bus.cmd_index == 6'd0) ? 8'h95 :
                         (bus.cmd_index == 6'd8) ? 8'h87 : 8'h01;
`endif

    assign frame_byte[0] = {2'b01, idx_reg};
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_arg_bytes
            assign frame_byte[gi + 1] = arg_reg[31 - 8 * gi -: 8];
        end
    endgenerate
    assign frame_byte[5] = crc_byte_reg;

    assign byte_idx = byte_cnt_reg + 3'd1;
    assign done_ok  = bus.spi_done && pending_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            idx_reg          <= '0;
            arg_reg          <= '0;
            long_reg         <= 1'b0;
            crc_byte_reg     <= 8'h01;
            byte_cnt_reg     <= '0;
            poll_cnt_reg     <= '0;
            ext_cnt_reg      <= '0;
            trail_cnt_reg    <= '0;
            pending_reg      <= 1'b0;
            spi_start_reg    <= 1'b0;
            spi_tx_reg       <= 8'hFF;
            spi_cs_n_reg     <= 1'b1;
            resp_valid_reg   <= 1'b0;
            resp_r1_reg      <= 8'hFF;
            resp_data_reg    <= '0;
            resp_timeout_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            idx_reg          <= idx_next;
            arg_reg          <= arg_next;
            long_reg         <= long_next;
            crc_byte_reg     <= crc_byte_next;
            byte_cnt_reg     <= byte_cnt_next;
            poll_cnt_reg     <= poll_cnt_next;
            ext_cnt_reg      <= ext_cnt_next;
            trail_cnt_reg    <= trail_cnt_next;
            pending_reg      <= pending_next;
            spi_start_reg    <= spi_start_next;
            spi_tx_reg       <= spi_tx_next;
            spi_cs_n_reg     <= spi_cs_n_next;
            resp_valid_reg   <= resp_valid_next;
            resp_r1_reg      <= resp_r1_next;
            resp_data_reg    <= resp_data_next;
            resp_timeout_reg <= resp_timeout_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        idx_next          = idx_reg;
        arg_next          = arg_reg;
        long_next         = long_reg;
        crc_byte_next     = crc_byte_reg;
        byte_cnt_next     = byte_cnt_reg;
        poll_cnt_next     = poll_cnt_reg;
        ext_cnt_next      = ext_cnt_reg;
        trail_cnt_next    = trail_cnt_reg;
        pending_next      = pending_reg;
        spi_start_next    = 1'b0;
        spi_tx_next       = spi_tx_reg;
        spi_cs_n_next     = spi_cs_n_reg;
        resp_valid_next   = 1'b0;
        resp_r1_next      = resp_r1_reg;
        resp_data_next    = resp_data_reg;
        resp_timeout_next = resp_timeout_reg;
        issue             = 1'b0;
        issue_byte        = 8'hFF;
        go_trail          = 1'b0;

        if (done_ok) pending_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    idx_next          = bus.cmd_index;
                    arg_next          = bus.cmd_arg;
                    long_next         = bus.cmd_long;
                    crc_byte_next     = crc_byte_in;
                    resp_data_next    = '0;
                    resp_timeout_next = 1'b0;
                    byte_cnt_next     = '0;
                    spi_cs_n_next     = 1'b0;
                    issue             = 1'b1;
                    issue_byte        = {2'b01, bus.cmd_index};
                    state_next        = SEND;
                end
            end
            SEND: begin
                if (done_ok) begin
                    issue = 1'b1;
                    if (byte_cnt_reg == 3'd5) begin
                        poll_cnt_next = 8'd1;
                        state_next    = POLL;
                    end else begin
                        byte_cnt_next = byte_idx;
                        issue_byte    = frame_byte[byte_idx];
                    end
                end
            end
            POLL: begin
                // A cleared MSB marks a valid R1; anything else is line idle.
                if (done_ok) begin
                    if (!bus.spi_rx[7]) begin
                        resp_r1_next = bus.spi_rx;
                        if (long_reg) begin
                            ext_cnt_next = '0;
                            issue        = 1'b1;
                            state_next   = EXT;
                        end else begin
                            go_trail = 1'b1;
                        end
                    end else if (poll_cnt_reg >= POLL_LAST) begin
                        resp_timeout_next = 1'b1;
                        resp_r1_next      = 8'hFF;
                        go_trail          = 1'b1;
                    end else begin
                        poll_cnt_next = poll_cnt_reg + 8'd1;
                        issue         = 1'b1;
                    end
                end
            end
            EXT: begin
                if (done_ok) begin
                    resp_data_next = {resp_data_reg[23:0], bus.spi_rx};
                    if (ext_cnt_reg == 2'd3) begin
                        go_trail = 1'b1;
                    end else begin
                        ext_cnt_next = ext_cnt_reg + 2'd1;
                        issue        = 1'b1;
                    end
                end
            end
            TRAIL: begin
                if (done_ok) begin
                    if (trail_cnt_reg == TRAIL_LAST) begin
                        resp_valid_next = 1'b1;
                        state_next      = DONE;
                    end else begin
                        trail_cnt_next = trail_cnt_reg + 2'd1;
                        issue          = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // cs is released before the first trailing byte so the card frees MISO.
        if (go_trail) begin
            spi_cs_n_next = 1'b1;
            if (TRAIL_BYTES == 0) begin
                resp_valid_next = 1'b1;
                state_next      = DONE;
            end else begin
                trail_cnt_next = '0;
                issue          = 1'b1;
                state_next     = TRAIL;
            end
        end

        if (issue) begin
            spi_start_next = 1'b1;
            spi_tx_next    = issue_byte;
            pending_next   = 1'b1;
        end
    end

    assign bus.cmd_ready    = (state_reg == IDLE);
    assign bus.resp_valid   = resp_valid_reg;
    assign bus.resp_r1      = resp_r1_reg;
    assign bus.resp_data    = resp_data_reg;
    assign bus.resp_timeout = resp_timeout_reg;
    assign bus.spi_start    = spi_start_reg;
    assign bus.spi_tx       = spi_tx_reg;
    assign bus.spi_cs_n     = spi_cs_n_reg;
endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
- Sequences one SD-card SPI-mode command transaction over the shared byte-level SPI rx/tx engine.
- Transaction steps:
  - assert cs;
  - send the 6-byte command frame (start/index, 32-bit argument, CRC7 + end bit);
  - poll 0xFF until an R1 byte arrives or the poll limit expires;
  - optionally read 4 trailing response bytes (R3/R7);
  - release cs and clock one trailing 0xFF.
- Sits between the SD init/normal-work state machine and the SPI byte engine.

Parameters:
- POLL_MAX, 8, maximum 0xFF poll bytes after the frame before a timeout is declared (1..255).
- TRAIL_BYTES, 1, number of 0xFF bytes sent with cs deasserted after the transaction (0..3).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- cmd_valid  input  1  request a command; sampled in IDLE only
- cmd_index  input  6  SD command index
- cmd_arg  input  32  command argument, sent MSB byte first
- cmd_long  input  1  1 = read 4 extra response bytes after R1
- cmd_ready  output  1  high in IDLE
- resp_valid  output  1  one-cycle pulse, result fields valid
- resp_r1  output  8  R1 byte received (0xFF on timeout)
- resp_data  output  32  extra response bytes, first byte in [31:24]; 0 if cmd_long=0
- resp_timeout  output  1  valid with resp_valid; 1 = no R1 within POLL_MAX
- spi_start  output  1  one-cycle pulse, starts one byte exchange
- spi_tx  output  8  byte to send; stable from the spi_start cycle until spi_done
- spi_done  input  1  one-cycle pulse from the engine, exchange finished
- spi_rx  input  8  received byte, valid with spi_done
- spi_cs_n  output  1  SD chip select, active-low

Behaviour:
- Reset values: cmd_ready=1, resp_valid=0, resp_r1=0xFF, resp_data=0, resp_timeout=0, spi_start=0, spi_tx=0xFF, spi_cs_n=1, state=IDLE.
- Reset mid-transaction aborts immediately to these values. No cleanup bytes are sent.
- States: IDLE, SEND, POLL, EXT, TRAIL, DONE.
- IDLE:
  - cmd_valid=1 latches index, arg and cmd_long, and computes the CRC.
  - Next cycle: spi_cs_n=0, spi_start=1, spi_tx=0x40|index, byte_cnt=0, go to SEND.
- Byte issue rule (all states):
  - the cycle after spi_done, the block pulses spi_start for the next byte;
  - at most one exchange is outstanding;
  - spi_done outside a pending exchange is ignored.
- SEND:
  - bytes in order: 0x40|idx, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc7,1'b1}.
  - After the 6th spi_done: go to POLL, issue 0xFF, poll_cnt=1.
- POLL:
  - each spi_done with spi_rx[7]=0: resp_r1=spi_rx. If cmd_long, go to EXT (4× 0xFF, ext_cnt 0..3); else go to TRAIL.
  - spi_rx[7]=1 and poll_cnt==POLL_MAX: resp_timeout=1, resp_r1=0xFF, skip EXT, go to TRAIL.
  - otherwise: poll_cnt+1 and issue 0xFF.
- EXT: each spi_rx shifts into resp_data from the MSB side: resp_data <= {resp_data[23:0], spi_rx}.
- TRAIL:
  - spi_cs_n=1 from entry.
  - Sends TRAIL_BYTES × 0xFF, then goes to DONE.
  - TRAIL_BYTES=0 goes straight to DONE with no exchange.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. Result fields hold until the next DONE.
- At command acceptance, resp_data and resp_timeout clear.
- Counters are 8-bit: poll_cnt saturates at POLL_MAX, with no wrap. byte_cnt is 3-bit (0..5).
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- A simultaneous cmd_valid on the DONE cycle is not accepted. It is accepted in IDLE the next cycle.
- Minimum latency, command accept to resp_valid: 2 + N×(engine byte time + 1) cycles, where N = 6 + polls + ext + trail.

Optional Feature:
- Macro SD_CRC7_EN.
- Defined:
  - CRC7 (polynomial x^7+x^3+1, init 0) is computed over the 40 bits {0x40|idx, arg}.
  - The CRC byte is {crc,1}.
- Undefined:
  - a fixed CRC byte: 0x95 for index 0, 0x87 for index 8, 0x01 otherwise (CRC off in SPI mode).
  - The CRC logic is not synthesized.

Test Plan:
- CMD0, arg 0, engine returns 0xFF,0x01 in poll → spi_tx sequence 40 00 00 00 00 95 FF FF then one trailing FF with cs_n=1; resp_r1=0x01, resp_timeout=0.
- CMD8, arg 0x000001AA, cmd_long=1, poll returns 0x01 then 00 00 01 AA → CRC byte 0x87, resp_data=0x000001AA, resp_r1=0x01.
- CMD17, arg 0x00001234, engine always returns 0xFF, POLL_MAX=8 → exactly 8 poll bytes, resp_timeout=1, resp_r1=0xFF, EXT skipped, cs_n released.
- With SD_CRC7_EN, CMD55 arg 0 → CRC byte 0x65. Without SD_CRC7_EN → CRC byte 0x01.
- Reset asserted during the 3rd SEND byte → spi_cs_n=1 and cmd_ready=1 immediately. A new CMD0 afterwards completes normally.
- cmd_valid held high through a transaction plus spurious spi_done pulses in IDLE → only one command accepted per IDLE visit, no extra spi_start, resp_valid single-cycle.
